// File: rtl/dmac_read_operation.sv
// Slave-side read path of the DMAC register block.
// Decodes a 3-bit register address on an accepted read and returns the selected
// register through a registered rdata/rvalid handshake with one cycle of latency.
// Also owns the sticky interrupt status bit, which is cleared when it is read.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | no read data pending, rvalid=0, a new request is always accepted
// S_VALID | rdata holds read data, rvalid=1, a new request needs rready
module dmac_read_operation #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  re,
  input  logic [2:0]            Addr,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic                  int_set,
  input  logic                  int_en,
  input  logic [DATA_WIDTH-1:0] src_reg,
  input  logic [DATA_WIDTH-1:0] dst_reg,
  input  logic [DATA_WIDTH-1:0] size_reg,
  input  logic [CNT_WIDTH-1:0]  desc_cnt,
  input  logic [DATA_WIDTH-1:0] opmode_reg,
  output logic                  interrupt
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_VALID = 1'b1
  } state_t;

  state_t                state;
  logic                  int_sticky;
  logic                  accept;
  logic [DATA_WIDTH-1:0] rd_mux;

  // A new read may be taken when nothing is pending or the pending one leaves now
  assign ready  = (state == S_IDLE) ? 1'b1 : rready;
  assign accept = re && ready;

  assign interrupt = int_sticky & int_en;

  // Register select; address 0 is the write-only START register and reads as zero
  always_comb begin
    rd_mux = '0;
    case (Addr)
      3'd0: rd_mux = '0;
      3'd1: rd_mux = {{(DATA_WIDTH-1){1'b0}}, int_sticky};
      3'd2: rd_mux = {{(DATA_WIDTH-1){1'b0}}, int_en};
      3'd3: rd_mux = src_reg;
      3'd4: rd_mux = dst_reg;
      3'd5: rd_mux = size_reg;
      3'd6: rd_mux = {{(DATA_WIDTH-CNT_WIDTH){1'b0}}, desc_cnt};
      3'd7: rd_mux = opmode_reg;
      default: rd_mux = '0;
    endcase
  end

  // Read handshake FSM; rdata only changes on an accepted request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (re) begin
            rdata  <= rd_mux;
            rvalid <= 1'b1;
            state  <= S_VALID;
          end
        end
        S_VALID: begin
          if (rready) begin
            if (re) begin
              rdata <= rd_mux;
            end else begin
              rvalid <= 1'b0;
              state  <= S_IDLE;
            end
          end
        end
        default: begin
          rvalid <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky interrupt: a new done pulse wins over a simultaneous read-to-clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int_sticky <= 1'b0;
    end else if (int_set) begin
      int_sticky <= 1'b1;
    end else if (accept && (Addr == 3'd1)) begin
      int_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmac_read_operation.sv
// Testbench for dmac_read_operation: directed scenarios followed by random
// traffic, all checked against a transaction-level model of the read port.
module tb_dmac_read_operation;

  logic        clk;
  logic        reset_n;
  logic        re;
  logic [2:0]  Addr;
  logic        ready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic        int_set;
  logic        int_en;
  logic [31:0] src_reg;
  logic [31:0] dst_reg;
  logic [31:0] size_reg;
  logic [3:0]  desc_cnt;
  logic [31:0] opmode_reg;
  logic        interrupt;

  int compared = 0;
  int mismatched = 0;

  // Model of what the consumer should see
  bit          m_valid;
  logic [31:0] m_data;
  bit          m_sticky;

  dmac_read_operation #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .re         (re),
    .Addr       (Addr),
    .ready      (ready),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .rready     (rready),
    .int_set    (int_set),
    .int_en     (int_en),
    .src_reg    (src_reg),
    .dst_reg    (dst_reg),
    .size_reg   (size_reg),
    .desc_cnt   (desc_cnt),
    .opmode_reg (opmode_reg),
    .interrupt  (interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value the register map says a read of address a returns right now
  function automatic logic [31:0] reg_value(input logic [2:0] a);
    logic [31:0] table_v [8];
    table_v[0] = 32'h0;
    table_v[1] = {31'h0, m_sticky};
    table_v[2] = {31'h0, int_en};
    table_v[3] = src_reg;
    table_v[4] = dst_reg;
    table_v[5] = size_reg;
    table_v[6] = {28'h0, desc_cnt};
    table_v[7] = opmode_reg;
    return table_v[a];
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_data   = 32'h0;
    m_sticky = 1'b0;
  endtask

  // One clock cycle: entered and left at a falling edge
  task automatic step(input logic re_v, input logic [2:0] a_v, input logic rr_v, input logic is_v);
    bit can_take;
    bit taken;
    re      = re_v;
    Addr    = a_v;
    rready  = rr_v;
    int_set = is_v;
    #1;
    can_take = !m_valid || rr_v;
    taken    = re_v && can_take;
    check("rvalid", {31'h0, rvalid}, {31'h0, m_valid});
    check("rdata", rdata, m_data);
    check("ready", {31'h0, ready}, {31'h0, can_take});
    check("interrupt", {31'h0, interrupt}, {31'h0, m_sticky & int_en});
    if (taken) begin
      m_data  = reg_value(a_v);
      m_valid = 1'b1;
    end else if (m_valid && rr_v) begin
      m_valid = 1'b0;
    end
    if (is_v) m_sticky = 1'b1;
    else if (taken && a_v == 3'd1) m_sticky = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n    = 1'b0;
    re         = 1'b0;
    Addr       = 3'd0;
    rready     = 1'b0;
    int_set    = 1'b0;
    int_en     = 1'b1;
    src_reg    = 32'h0;
    dst_reg    = 32'h0;
    size_reg   = 32'h0;
    desc_cnt   = 4'h0;
    opmode_reg = 32'h0;
    model_reset();

    // Reset values
    #2;
    check("rst_rvalid", {31'h0, rvalid}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_interrupt", {31'h0, interrupt}, 32'h0);
    check("rst_ready", {31'h0, ready}, 32'h1);
    @(negedge clk);
    reset_n = 1'b1;

    // Single read of src_reg
    src_reg = 32'h1000;
    step(1'b1, 3'd3, 1'b1, 1'b0);
    check("single_rvalid", {31'h0, rvalid}, 32'h1);
    check("single_rdata", rdata, 32'h1000);
    step(1'b0, 3'd0, 1'b1, 1'b0);
    check("single_drop", {31'h0, rvalid}, 32'h0);
    check("single_hold", rdata, 32'h1000);

    // Back-to-back reads of dst, size, opmode
    dst_reg    = 32'h2222_0004;
    size_reg   = 32'h0000_0155;
    opmode_reg = 32'h8000_0007;
    step(1'b1, 3'd4, 1'b1, 1'b0);
    check("b2b_dst", rdata, 32'h2222_0004);
    step(1'b1, 3'd5, 1'b1, 1'b0);
    check("b2b_size", rdata, 32'h0000_0155);
    check("b2b_valid", {31'h0, rvalid}, 32'h1);
    step(1'b1, 3'd7, 1'b1, 1'b0);
    check("b2b_opmode", rdata, 32'h8000_0007);
    step(1'b0, 3'd0, 1'b1, 1'b0);

    // Backpressure: a held read of size_reg survives a register change and new requests
    size_reg = 32'h0000_0AAA;
    step(1'b1, 3'd5, 1'b1, 1'b0);
    size_reg = 32'h0000_0BBB;
    step(1'b1, 3'd3, 1'b0, 1'b0);
    step(1'b1, 3'd4, 1'b0, 1'b0);
    step(1'b1, 3'd7, 1'b0, 1'b0);
    check("stall_rdata", rdata, 32'h0000_0AAA);
    check("stall_rvalid", {31'h0, rvalid}, 32'h1);
    step(1'b0, 3'd0, 1'b1, 1'b0);

    // Other addresses: START, int_en, desc_cnt
    desc_cnt = 4'hD;
    step(1'b1, 3'd6, 1'b1, 1'b0);
    check("desc_cnt", rdata, 32'h0000_000D);
    step(1'b1, 3'd0, 1'b1, 1'b0);
    check("start_zero", rdata, 32'h0);
    step(1'b1, 3'd2, 1'b1, 1'b0);
    check("int_en_rd", rdata, 32'h1);
    step(1'b0, 3'd0, 1'b1, 1'b0);

    // Sticky interrupt read-to-clear
    step(1'b0, 3'd0, 1'b1, 1'b1);
    check("irq_set", {31'h0, interrupt}, 32'h1);
    step(1'b1, 3'd1, 1'b1, 1'b0);
    check("irq_read1", rdata, 32'h1);
    check("irq_cleared", {31'h0, interrupt}, 32'h0);
    step(1'b1, 3'd1, 1'b1, 1'b0);
    check("irq_read0", rdata, 32'h0);
    step(1'b0, 3'd0, 1'b1, 1'b0);

    // Set in the same cycle as an accepted read of the sticky bit
    step(1'b1, 3'd1, 1'b1, 1'b1);
    check("irq_race_rdata", rdata, 32'h0);
    check("irq_race_sticky", {31'h0, interrupt}, 32'h1);
    step(1'b0, 3'd0, 1'b1, 1'b0);

    // A stalled read of the sticky bit must not clear it
    step(1'b1, 3'd3, 1'b0, 1'b0);
    step(1'b1, 3'd1, 1'b0, 1'b0);
    step(1'b1, 3'd1, 1'b0, 1'b0);
    check("irq_stall_keep", {31'h0, interrupt}, 32'h1);
    step(1'b0, 3'd0, 1'b1, 1'b0);

    // Asynchronous reset while data is held
    src_reg = 32'h0000_ABCD;
    step(1'b1, 3'd3, 1'b0, 1'b0);
    check("pre_rst_rdata", rdata, 32'h0000_ABCD);
    re = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rvalid", {31'h0, rvalid}, 32'h0);
    check("async_rdata", rdata, 32'h0);
    check("async_irq", {31'h0, interrupt}, 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      src_reg    = $urandom;
      dst_reg    = $urandom;
      size_reg   = $urandom;
      opmode_reg = $urandom;
      desc_cnt   = 4'($urandom_range(0, 15));
      int_en     = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
